// File: rtl/triangle_channel.sv
// Triangle-style waveform channel: timer, step sequencer, linear and length
// counters with channel gating, and a registered sample for the mixer.
module triangle_channel #(
    parameter int TIMER_W   = 11,
    parameter int DAC_W     = 4,
    parameter int LIN_W     = 7,
    parameter int ULTRA_MIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timer_tick,
    input  logic               enable_240hz,
    input  logic               enable_120hz,
    input  logic               lin_control,
    input  logic [LIN_W-1:0]   lin_preset,
    input  logic [TIMER_W-1:0] period,
    input  logic [4:0]         length_select,
    input  logic               reload_pulse,
    input  logic               channel_en,
    input  logic [1:0]         mode,
    output logic [DAC_W-1:0]   wave_out,
    output logic               active
);

    localparam int SEQ_W = DAC_W + 1;
    localparam logic [TIMER_W-1:0] ULTRA_LIMIT = TIMER_W'(ULTRA_MIN);
    localparam logic [DAC_W-1:0]   MIDPOINT    = {1'b1, {(DAC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_TRIANGLE = 2'b00,
        MODE_SAW_UP   = 2'b01,
        MODE_SAW_DOWN = 2'b10,
        MODE_SILENT   = 2'b11
    } mode_t;

    function automatic logic [7:0] length_lut(input logic [4:0] idx);
        logic [7:0] val;
        val = 8'd0;
        case (idx)
            5'd0:  val = 8'd10;
            5'd1:  val = 8'd254;
            5'd2:  val = 8'd20;
            5'd3:  val = 8'd2;
            5'd4:  val = 8'd40;
            5'd5:  val = 8'd4;
            5'd6:  val = 8'd80;
            5'd7:  val = 8'd6;
            5'd8:  val = 8'd160;
            5'd9:  val = 8'd8;
            5'd10: val = 8'd60;
            5'd11: val = 8'd10;
            5'd12: val = 8'd14;
            5'd13: val = 8'd12;
            5'd14: val = 8'd26;
            5'd15: val = 8'd14;
            5'd16: val = 8'd12;
            5'd17: val = 8'd16;
            5'd18: val = 8'd24;
            5'd19: val = 8'd18;
            5'd20: val = 8'd48;
            5'd21: val = 8'd20;
            5'd22: val = 8'd96;
            5'd23: val = 8'd22;
            5'd24: val = 8'd192;
            5'd25: val = 8'd24;
            5'd26: val = 8'd72;
            5'd27: val = 8'd26;
            5'd28: val = 8'd16;
            5'd29: val = 8'd28;
            5'd30: val = 8'd32;
            5'd31: val = 8'd30;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

    logic [TIMER_W-1:0] timer;
    logic [SEQ_W-1:0]   seq;
    logic [LIN_W-1:0]   linear;
    logic [7:0]         length;
    logic               reload_flag;

    logic               step_en;
    logic               seq_advance;
    logic [7:0]         length_next;
    logic [LIN_W-1:0]   linear_next;
    logic               flag_set;
    logic               flag_next;
    logic               ultrasonic;
    logic [DAC_W-1:0]   lo;
    logic [DAC_W-1:0]   hi;
    logic [DAC_W-1:0]   sample;

    always_comb begin
        step_en     = timer_tick && (timer == '0);
        seq_advance = step_en && (linear != '0) && (length != 8'd0);
        ultrasonic  = (period < ULTRA_LIMIT);
    end

    // Disable beats a $400B write; a write beats the half-frame decrement.
    always_comb begin
        length_next = length;
        if (!channel_en) begin
            length_next = 8'd0;
        end else if (reload_pulse) begin
            length_next = length_lut(length_select);
        end else if (enable_120hz && !lin_control && (length != 8'd0)) begin
            length_next = length - 8'd1;
        end
    end

    // A write in the same cycle as the quarter-frame strobe counts as already set
    // and survives that strobe even when lin_control is low.
    always_comb begin
        flag_set    = reload_flag | reload_pulse;
        linear_next = linear;
        flag_next   = flag_set;
        if (enable_240hz) begin
            if (flag_set) begin
                linear_next = lin_preset;
            end else if (linear != '0) begin
                linear_next = linear - LIN_W'(1);
            end
            if (!lin_control && !reload_pulse) begin
                flag_next = 1'b0;
            end
        end
    end

    always_comb begin
        lo     = seq[DAC_W-1:0];
        hi     = seq[DAC_W:1];
        sample = '0;
        if ((mode_t'(mode) != MODE_SILENT) && ultrasonic) begin
            sample = MIDPOINT;
        end else begin
            case (mode_t'(mode))
                MODE_TRIANGLE: sample = seq[DAC_W] ? lo : ~lo;
                MODE_SAW_UP:   sample = hi;
                MODE_SAW_DOWN: sample = ~hi;
                default:       sample = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer       <= '0;
            seq         <= '0;
            linear      <= '0;
            length      <= 8'd0;
            reload_flag <= 1'b0;
            wave_out    <= '0;
            active      <= 1'b0;
        end else begin
            if (timer_tick) begin
                timer <= (timer == '0) ? period : (timer - TIMER_W'(1));
            end
            if (seq_advance) begin
                seq <= seq + SEQ_W'(1);
            end
            length      <= length_next;
            active      <= (length_next != 8'd0);
            linear      <= linear_next;
            reload_flag <= flag_next;
            wave_out    <= sample;
        end
    end

endmodule

// File: tb/tb_triangle_channel.sv
// Directed bench for triangle_channel; expectations are queued before each
// clock and drained against the outputs just after that clock.
module tb_triangle_channel;

    logic        clk = 1'b0;
    logic        rst;
    logic        timer_tick;
    logic        enable_240hz;
    logic        enable_120hz;
    logic        lin_control;
    logic [6:0]  lin_preset;
    logic [10:0] period;
    logic [4:0]  length_select;
    logic        reload_pulse;
    logic        channel_en;
    logic [1:0]  mode;
    logic [3:0]  wave_out;
    logic        active;

    int total = 0;
    int bad   = 0;

    string sb_tag[$];
    int    sb_kind[$];
    int    sb_val[$];

    triangle_channel dut (
        .clk           (clk),
        .rst           (rst),
        .timer_tick    (timer_tick),
        .enable_240hz  (enable_240hz),
        .enable_120hz  (enable_120hz),
        .lin_control   (lin_control),
        .lin_preset    (lin_preset),
        .period        (period),
        .length_select (length_select),
        .reload_pulse  (reload_pulse),
        .channel_en    (channel_en),
        .mode          (mode),
        .wave_out      (wave_out),
        .active        (active)
    );

    always #5 clk = ~clk;

    // Reference shapes written from the waveform description, not the bit mapping.
    function automatic int tri_val(input int k);
        int idx;
        idx = k % 32;
        return (idx < 16) ? (15 - idx) : (idx - 16);
    endfunction

    function automatic int saw_val(input int k);
        return (k % 32) / 2;
    endfunction

    task automatic expect_wave(input string tag, input int val);
        sb_tag.push_back(tag);
        sb_kind.push_back(0);
        sb_val.push_back(val);
    endtask

    task automatic expect_active(input string tag, input int val);
        sb_tag.push_back(tag);
        sb_kind.push_back(1);
        sb_val.push_back(val);
    endtask

    task automatic check_output();
        string tag;
        int    kind;
        int    val;
        int    got;
        while (sb_tag.size() > 0) begin
            tag  = sb_tag.pop_front();
            kind = sb_kind.pop_front();
            val  = sb_val.pop_front();
            got  = (kind == 0) ? int'(wave_out) : int'(active);
            total++;
            assert (got === val) else begin
                bad++;
                $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic run_ticks(input int n);
        timer_tick = 1'b1;
        repeat (n) step();
        timer_tick = 1'b0;
    endtask

    task automatic pulse_240();
        enable_240hz = 1'b1;
        step();
        enable_240hz = 1'b0;
    endtask

    task automatic apply_stimulus_defaults();
        timer_tick    = 1'b0;
        enable_240hz  = 1'b0;
        enable_120hz  = 1'b0;
        lin_control   = 1'b0;
        lin_preset    = 7'd0;
        length_select = 5'd0;
        reload_pulse  = 1'b0;
        channel_en    = 1'b0;
    endtask

    task automatic do_reset(input logic [10:0] p, input logic [1:0] m);
        apply_stimulus_defaults();
        period = p;
        mode   = m;
        rst    = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    // Enables the channel, loads the length, and loads the linear counter once.
    task automatic setup_gate(input logic ctl, input logic [6:0] preset, input logic [4:0] sel);
        channel_en    = 1'b1;
        lin_control   = ctl;
        lin_preset    = preset;
        length_select = sel;
        reload_pulse  = 1'b1;
        step();
        reload_pulse = 1'b0;
        pulse_240();
    endtask

    initial begin
        apply_stimulus_defaults();
        period = 11'd3;
        mode   = 2'b00;
        rst    = 1'b1;

        // Reset held for three clocks, then the first valid sample.
        for (int i = 0; i < 3; i++) begin
            expect_wave("reset_wave", 0);
            expect_active("reset_active", 0);
            step();
        end
        rst = 1'b0;
        expect_wave("first_sample", 15);
        expect_active("first_active", 0);
        step();

        $display("[TB] triangle sequence");
        do_reset(11'd3, 2'b00);
        setup_gate(1'b1, 7'd127, 5'd1);
        expect_active("tri_active", 1);
        expect_wave("tri_idle", 15);
        step();
        timer_tick = 1'b1;
        for (int n = 1; n <= 132; n++) begin
            expect_wave("tri_step", tri_val((n + 2) / 4));
            step();
        end
        timer_tick = 1'b0;

        $display("[TB] length expiry");
        do_reset(11'd3, 2'b00);
        setup_gate(1'b0, 7'd127, 5'd3);
        timer_tick = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            expect_wave("len_run", tri_val((n + 2) / 4));
            step();
        end
        enable_120hz = 1'b1;
        expect_active("len_first_dec", 1);
        step();
        expect_active("len_expired", 0);
        expect_wave("len_expired_wave", 12);
        step();
        enable_120hz = 1'b0;
        for (int n = 13; n <= 32; n++) begin
            expect_wave("len_frozen", 12);
            step();
        end
        timer_tick = 1'b0;

        $display("[TB] linear reload flag");
        do_reset(11'd3, 2'b00);
        setup_gate(1'b0, 7'd2, 5'd1);
        run_ticks(8);
        expect_wave("lin_at_2", 13);
        step();
        pulse_240();
        run_ticks(4);
        expect_wave("lin_at_1", 12);
        step();
        pulse_240();
        run_ticks(8);
        expect_wave("lin_at_0", 12);
        step();
        pulse_240();
        run_ticks(4);
        expect_wave("lin_stays_0", 12);
        step();
        lin_control  = 1'b1;
        reload_pulse = 1'b1;
        step();
        reload_pulse = 1'b0;
        repeat (3) pulse_240();
        run_ticks(8);
        expect_wave("lin_held_reload", 10);
        step();

        $display("[TB] write and quarter-frame together");
        do_reset(11'd3, 2'b00);
        channel_en    = 1'b1;
        lin_control   = 1'b0;
        lin_preset    = 7'd1;
        length_select = 5'd1;
        reload_pulse  = 1'b1;
        enable_240hz  = 1'b1;
        step();
        reload_pulse = 1'b0;
        enable_240hz = 1'b0;
        run_ticks(4);
        expect_wave("same_cycle_load", 14);
        step();
        pulse_240();
        run_ticks(4);
        expect_wave("flag_survived", 13);
        step();
        pulse_240();
        run_ticks(4);
        expect_wave("flag_then_cleared", 13);
        step();

        $display("[TB] length priority");
        do_reset(11'd3, 2'b00);
        channel_en    = 1'b0;
        length_select = 5'd1;
        reload_pulse  = 1'b1;
        expect_active("disabled_reload", 0);
        step();
        channel_en    = 1'b1;
        lin_control   = 1'b0;
        length_select = 5'd3;
        enable_120hz  = 1'b1;
        expect_active("reload_beats_dec", 1);
        step();
        reload_pulse = 1'b0;
        expect_active("len_2_to_1", 1);
        step();
        expect_active("len_1_to_0", 0);
        step();
        enable_120hz  = 1'b0;
        length_select = 5'd1;
        reload_pulse  = 1'b1;
        expect_active("reload_254", 1);
        step();
        reload_pulse = 1'b0;
        channel_en   = 1'b0;
        expect_active("disable_clears", 0);
        step();
        channel_en    = 1'b1;
        lin_control   = 1'b1;
        length_select = 5'd3;
        reload_pulse  = 1'b1;
        step();
        reload_pulse = 1'b0;
        enable_120hz = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_active("halt_holds_len", 1);
            step();
        end
        enable_120hz = 1'b0;

        $display("[TB] ultrasonic and modes");
        do_reset(11'd1, 2'b00);
        expect_wave("ultra_mid", 8);
        step();
        setup_gate(1'b1, 7'd127, 5'd1);
        timer_tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_wave("ultra_running", 8);
            step();
        end
        timer_tick = 1'b0;
        period     = 11'd3;
        expect_wave("ultra_seq_kept", 12);
        step();

        do_reset(11'd3, 2'b01);
        setup_gate(1'b1, 7'd127, 5'd1);
        timer_tick = 1'b1;
        for (int n = 1; n <= 132; n++) begin
            expect_wave("saw_up", saw_val((n + 2) / 4));
            step();
        end
        timer_tick = 1'b0;
        mode = 2'b10;
        expect_wave("saw_down", 15);
        step();
        mode = 2'b11;
        expect_wave("silent", 0);
        step();
        period = 11'd1;
        expect_wave("silent_ultra", 0);
        step();
        mode = 2'b00;
        expect_wave("tri_ultra", 8);
        step();
        period = 11'd3;
        expect_wave("tri_resume", 14);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
